mem_stage_sram_ctrl: RTL

MEM stage of the ARM pipeline. It consumes the EXE/MEM pipeline register outputs (write-back, memory read and memory write enables, ALU result, Rm value, destination register) and performs loads and stores against an external 16-bit SRAM. Each 32-bit access is done as two half-word transfers. While an access is in flight the block drives `ready` low to freeze the upstream pipeline, and it produces the registered MEM/WB outputs for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 49 ++++
 rtl/mem_stage_sram_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM stage SRAM controller
package mem_stage_pkg;

    localparam int SRAM_DW    = 16;
    localparam int SRAM_AW    = 18;
    localparam int WORD_IDX_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    // Phase counter width: enough to hold SRAM_WAIT, never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion while the stage stalls
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ready             1: load a new instruction, 0: load a bubble (enables cleared, data held)
//   wb_en_in, mem_r_en_in, alu_res_in, dest_in   fields from the EXE/MEM register
//   load_rd           current op is a true read; only then is mem_data updated
//   load_data         assembled {hi,lo} half-words from the SRAM
//   wb_en, mem_r_en, alu_res, mem_data, dest      registered MEM/WB outputs
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        load_rd,
    input  logic [31:0] alu_res_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] load_data,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic [31:0] alu_res,
    output logic [31:0] mem_data,
    output logic [3:0]  dest
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            alu_res  <= '0;
            mem_data <= '0;
            dest     <= '0;
        end else if (ready) begin
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            alu_res  <= alu_res_in;
            dest     <= dest_in;
            if (load_rd) begin
                mem_data <= load_data;
            end
        end else begin
            // Stall: emit a bubble so write-back does nothing; payload fields hold.
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - ARM MEM stage doing 32-bit loads/stores as two 16-bit SRAM transfers
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in   EXE/MEM register outputs
//   ready                         1 when a new instruction can be accepted (upstream freezes on 0)
//   wb_en, mem_r_en, alu_res, mem_data, dest                             MEM/WB register outputs
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n           16-bit SRAM port
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BASE = 1024,
    parameter int SRAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic [31:0]        alu_res_in,
    input  logic [31:0]        val_rm_in,
    input  logic [3:0]         dest_in,
    output logic               ready,
    output logic               wb_en,
    output logic               mem_r_en,
    output logic [31:0]        alu_res,
    output logic [31:0]        mem_data,
    output logic [3:0]         dest,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam int            CW       = cnt_width(SRAM_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SRAM_DW-1:0]    lo_q, hi_q;
    logic [WORD_IDX_W-1:0] word_idx;
    logic                  mem_req;
    logic                  is_rd;
    logic                  phase_last;
    logic                  in_xfer;

    assign mem_req    = mem_r_en_in | mem_w_en_in;
    // A simultaneous read+write request is treated as a store.
    assign is_rd      = mem_r_en_in & ~mem_w_en_in;
    assign phase_last = (cnt_q == CNT_LAST);
    assign in_xfer    = (state_q == ST_LO) || (state_q == ST_HI);
    assign word_idx   = WORD_IDX_W'((alu_res_in - 32'(ADDR_BASE)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mem_req) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data is sampled on the final wait cycle of each half so the SRAM has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (is_rd && phase_last) begin
            if (state_q == ST_LO) begin
                lo_q <= sram_dq_in;
            end
            if (state_q == ST_HI) begin
                hi_q <= sram_dq_in;
            end
        end
    end

    // SRAM drive is suppressed during reset so an abandoned store cannot write its
    // high half on the reset edge.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (!rst && in_xfer) begin
            sram_addr = {word_idx, (state_q == ST_HI)};
            if (mem_w_en_in) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = (state_q == ST_HI) ? val_rm_in[31:16] : val_rm_in[15:0];
            end
        end
    end

    assign ready = rst
                 | ((state_q == ST_IDLE) & ~mem_req)
                 | (state_q == ST_DONE);

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .load_rd     (is_rd),
        .alu_res_in  (alu_res_in),
        .dest_in     (dest_in),
        .load_data   ({hi_q, lo_q}),
        .wb_en       (wb_en),
        .mem_r_en    (mem_r_en),
        .alu_res     (alu_res),
        .mem_data    (mem_data),
        .dest        (dest)
    );

endmodule
